// File: rtl/clk_meter_pkg.sv
// Shared definitions for the clock frequency meter and its helpers.
//   meter_state_t       : measurement FSM states
//   METER_CNT_W         : default counter / measurement width
//   METER_TIMEOUT       : default cycles without a rising edge before stall
//   METER_EXP_PERIOD    : default expected period in clk_in cycles
//   METER_TOL           : default allowed period deviation (inclusive)
package clk_meter_pkg;

    localparam int METER_CNT_W      = 16;
    localparam int METER_TIMEOUT    = 65535;
    localparam int METER_EXP_PERIOD = 256;
    localparam int METER_TOL        = 2;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ARMED   = 2'd1,
        STALLED = 2'd2
    } meter_state_t;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer plus rising-edge detector for a slow asynchronous input.
// Ports:
//   clk_in  : system clock
//   rst_n   : asynchronous active-low reset
//   sig_in  : asynchronous input
//   sig_s   : synchronized copy of sig_in
//   rise    : one-cycle pulse in the first cycle sig_s is seen high
module sync_edge_detect (
    input  logic clk_in,
    input  logic rst_n,
    input  logic sig_in,
    output logic sig_s,
    output logic rise
);

    logic sync_q;
    logic sig_d;

    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 1'b0;
            sig_s  <= 1'b0;
            sig_d  <= 1'b0;
        end else begin
            sync_q <= sig_in;
            sig_s  <= sync_q;
            sig_d  <= sig_s;
        end
    end

    assign rise = sig_s & ~sig_d;

endmodule

// File: rtl/clock_freq_meter.sv
// Measures period and high time of a slow square wave in clk_in cycles and
// flags whether the period lies within EXP_PERIOD +/- TOL.
// Ports:
//   clk_in     : system clock
//   rst_n      : asynchronous active-low reset
//   sig_in     : measured signal, asynchronous to clk_in
//   period_o   : last complete period in cycles
//   high_o     : high cycles within that period
//   meas_valid : one-cycle pulse when the measurement outputs update
//   in_range   : period_o within EXP_PERIOD +/- TOL
//   stalled    : no rising edge seen for TIMEOUT cycles
module clock_freq_meter
    import clk_meter_pkg::*;
#(
    parameter int CNT_W      = METER_CNT_W,
    parameter int EXP_PERIOD = METER_EXP_PERIOD,
    parameter int TOL        = METER_TOL,
    parameter int TIMEOUT    = METER_TIMEOUT
) (
    input  logic             clk_in,
    input  logic             rst_n,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period_o,
    output logic [CNT_W-1:0] high_o,
    output logic             meas_valid,
    output logic             in_range,
    output logic             stalled
);

    localparam logic [CNT_W-1:0] CNT_MAX   = '1;
    localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0] TIMEOUT_C = CNT_W'(TIMEOUT);
    // Window bounds carry one extra bit so EXP_PERIOD + TOL cannot wrap;
    // a negative lower bound clamps to zero.
    localparam logic [CNT_W:0]   RANGE_LO  = (EXP_PERIOD > TOL) ? (CNT_W+1)'(EXP_PERIOD - TOL) : '0;
    localparam logic [CNT_W:0]   RANGE_HI  = (CNT_W+1)'(EXP_PERIOD + TOL);

    logic             sig_s;
    logic             rise;
    logic [CNT_W-1:0] pcnt;
    logic [CNT_W-1:0] hcnt;
    logic [CNT_W:0]   pcnt_ext;
    logic             pcnt_in_range;
    meter_state_t     state;

    sync_edge_detect u_sync (
        .clk_in (clk_in),
        .rst_n  (rst_n),
        .sig_in (sig_in),
        .sig_s  (sig_s),
        .rise   (rise)
    );

    assign pcnt_ext      = {1'b0, pcnt};
    assign pcnt_in_range = (pcnt_ext >= RANGE_LO) && (pcnt_ext <= RANGE_HI);

    // Both counters restart at 1 on the rise cycle, so the value held when
    // the next rise arrives equals the full period / high time.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            pcnt <= '0;
            hcnt <= '0;
        end else if (rise) begin
            pcnt <= CNT_ONE;
            hcnt <= CNT_ONE;
        end else begin
            if (pcnt != CNT_MAX)
                pcnt <= pcnt + CNT_ONE;
            if (sig_s && (hcnt != CNT_MAX))
                hcnt <= hcnt + CNT_ONE;
        end
    end

    // A rise in ARMED always captures, even when pcnt hits TIMEOUT that cycle.
    always_ff @(posedge clk_in or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            period_o   <= '0;
            high_o     <= '0;
            meas_valid <= 1'b0;
            in_range   <= 1'b0;
            stalled    <= 1'b0;
        end else begin
            meas_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (rise)
                        state <= ARMED;
                end
                ARMED: begin
                    if (rise) begin
                        period_o   <= pcnt;
                        high_o     <= hcnt;
                        in_range   <= pcnt_in_range;
                        meas_valid <= 1'b1;
                    end else if (pcnt == TIMEOUT_C) begin
                        state   <= STALLED;
                        stalled <= 1'b1;
                    end
                end
                STALLED: begin
                    // The period ending here is partial, so no capture.
                    if (rise) begin
                        state   <= ARMED;
                        stalled <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_clock_freq_meter.sv
// Directed bench for clock_freq_meter: synchronous waves of several periods,
// tolerance edges, stall/restart, asynchronous reset and an unrelated-clock wave.
module tb_clock_freq_meter;

    localparam int CNT_W = 16;

    logic             clk_in = 1'b0;
    logic             aclk   = 1'b0;
    logic             rst_n  = 1'b0;
    logic             sig_in;
    logic [CNT_W-1:0] period_o;
    logic [CNT_W-1:0] high_o;
    logic             meas_valid;
    logic             in_range;
    logic             stalled;

    // 0: hold low, 1: synchronous wave, 2: wave from the unrelated clock
    int   mode      = 0;
    int   gen_per   = 256;
    int   gen_high  = 128;
    logic sync_sig  = 1'b0;
    logic async_sig = 1'b0;

    int   cyc     = 0;
    int   n_valid = 0;
    int   last_cyc = 0;
    int   last_per = 0;
    int   last_high = 0;
    int   last_inr = 0;

    int   checks = 0;
    int   errors = 0;

    assign sig_in = (mode == 2) ? async_sig : sync_sig;

    clock_freq_meter #(.TIMEOUT(1000)) dut (
        .clk_in     (clk_in),
        .rst_n      (rst_n),
        .sig_in     (sig_in),
        .period_o   (period_o),
        .high_o     (high_o),
        .meas_valid (meas_valid),
        .in_range   (in_range),
        .stalled    (stalled)
    );

    initial forever #500 clk_in = ~clk_in;

    // Unrelated clock, slightly slower than clk_in and phase-shifted.
    initial begin
        #137;
        forever #501 aclk = ~aclk;
    end

    always @(posedge clk_in) cyc <= cyc + 1;

    // Synchronous wave generator
    initial begin : sync_gen
        int ph;
        ph = 0;
        forever begin
            @(negedge clk_in);
            if (mode != 1) begin
                ph = 0;
                sync_sig = 1'b0;
            end else begin
                sync_sig = (ph < gen_high);
                ph = (ph + 1 >= gen_per) ? 0 : ph + 1;
            end
        end
    end

    // 256-cycle wave on the unrelated clock, starting after a 37-cycle offset
    initial begin : async_gen
        int aph;
        aph = 0;
        forever begin
            @(posedge aclk);
            if (mode != 2) begin
                aph = 0;
                async_sig = 1'b0;
            end else begin
                if (aph >= 37)
                    async_sig = (((aph - 37) % 256) < 128);
                aph++;
            end
        end
    end

    // Record every measurement pulse
    initial forever begin
        @(negedge clk_in);
        if (meas_valid) begin
            n_valid++;
            last_cyc  = cyc;
            last_per  = int'(period_o);
            last_high = int'(high_o);
            last_inr  = int'(in_range);
        end
    end

    task automatic check(input string tag, input int obs, input int exp_v);
        checks++;
        if (obs !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp_v);
        end
    endtask

    task automatic wait_valid(input string tag);
        int target;
        target = n_valid + 1;
        for (int i = 0; i < 1500 && n_valid < target; i++)
            @(posedge clk_in);
        check({tag, "_arrive"}, (n_valid >= target) ? 1 : 0, 1);
    endtask

    task automatic set_wave(input int per, input int high, input string tag);
        mode = 0;
        repeat (10) @(posedge clk_in);
        gen_per  = per;
        gen_high = high;
        mode     = 1;
        wait_valid({tag, "_settle"});
        wait_valid(tag);
    endtask

    task automatic check_meas(input string tag, input int per, input int high, input int inr);
        check({tag, "_period"}, last_per, per);
        check({tag, "_high"}, last_high, high);
        check({tag, "_inrange"}, last_inr, inr);
    endtask

    initial begin : main
        int c1;
        int p0;
        int nv;

        // Reset state
        repeat (2) @(negedge clk_in);
        check("rst0_period", int'(period_o), 0);
        check("rst0_high", int'(high_o), 0);
        check("rst0_valid", int'(meas_valid), 0);
        check("rst0_inrange", int'(in_range), 0);
        check("rst0_stalled", int'(stalled), 0);
        rst_n = 1'b1;
        repeat (2) @(posedge clk_in);

        // Nominal 256-cycle wave: no pulse on the first edge
        gen_per  = 256;
        gen_high = 128;
        mode     = 1;
        repeat (250) @(posedge clk_in);
        check("first_edge_nopulse", n_valid, 0);
        wait_valid("nom1");
        check_meas("nom1", 256, 128, 1);
        c1 = last_cyc;
        wait_valid("nom2");
        check("nom_interval", last_cyc - c1, 256);
        check_meas("nom2", 256, 128, 1);
        @(negedge clk_in);
        check("pulse_width", int'(meas_valid), 0);
        check("hold_period", int'(period_o), 256);

        // I2C-rate wave and tolerance edges
        set_wave(300, 150, "p300");
        check_meas("p300", 300, 150, 0);
        set_wave(258, 129, "p258");
        check_meas("p258", 258, 129, 1);
        set_wave(259, 129, "p259");
        check_meas("p259", 259, 129, 0);
        set_wave(254, 127, "p254");
        check_meas("p254", 254, 127, 1);
        set_wave(253, 126, "p253");
        check_meas("p253", 253, 126, 0);

        // Stall: last rise one cycle before the pulse, stalled 1001 cycles after it
        set_wave(256, 128, "pre_stall");
        check_meas("pre_stall", 256, 128, 1);
        p0   = last_cyc;
        mode = 0;
        while (cyc < p0 + 999) @(negedge clk_in);
        check("stall_early", int'(stalled), 0);
        @(negedge clk_in);
        check("stall_at", int'(stalled), 1);
        check("stall_hold_period", int'(period_o), 256);
        nv   = n_valid;
        mode = 1;
        for (int i = 0; i < 20 && stalled; i++) @(negedge clk_in);
        check("stall_clear", int'(stalled), 0);
        check("stall_clear_nopulse", int'(meas_valid), 0);
        @(posedge clk_in);
        check("stall_clear_count", n_valid, nv);
        wait_valid("restart");
        check_meas("restart", 256, 128, 1);

        // Asynchronous reset during the low phase
        wait_valid("pre_rst");
        p0 = last_cyc;
        while (cyc < p0 + 180) @(negedge clk_in);
        #100 rst_n = 1'b0;
        #1;
        check("arst_period", int'(period_o), 0);
        check("arst_high", int'(high_o), 0);
        check("arst_valid", int'(meas_valid), 0);
        check("arst_inrange", int'(in_range), 0);
        check("arst_stalled", int'(stalled), 0);
        repeat (3) @(posedge clk_in);
        @(negedge clk_in);
        rst_n = 1'b1;
        wait_valid("post_rst");
        check("post_rst_cycle", last_cyc - p0, 512);
        check_meas("post_rst", 256, 128, 1);

        // Wave from the unrelated clock
        mode = 0;
        repeat (10) @(posedge clk_in);
        mode = 2;
        wait_valid("async_settle");
        for (int k = 0; k < 5; k++) begin
            wait_valid("async");
            check("async_period_window", (last_per >= 255 && last_per <= 257) ? 1 : 0, 1);
            check("async_inrange", last_inr, 1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/clock_freq_meter.md
# clock_freq_meter

Measures the period and high time of a slow, asynchronous square wave (a divided clock, PWM or I2C clock line) in cycles of the system clock and flags whether it falls inside an expected window. It is the checking counterpart to the clock dividers: a divider produces a slow clock from `clk_in`, and this block reads it back and reports its rate and duty. It sits beside the divider outputs and feeds the status and debug register path.

## Interface
Parameters:
- `CNT_W`, 16: width of all counters and measurement outputs.
- `EXP_PERIOD`, 256: expected period in `clk_in` cycles.
- `TOL`, 2: allowed absolute deviation from `EXP_PERIOD`, inclusive.
- `TIMEOUT`, 65535: cycles without a rising edge before `stalled` asserts. Must be ≤ 2^CNT_W−1.

Ports:
- `clk_in`  in  1  system clock. Only clock.
- `rst_n`  in  1  reset, asynchronous assert, active-low.
- `sig_in`  in  1  measured signal, asynchronous to `clk_in`.
- `period_o`  out  CNT_W  last complete period, in cycles.
- `high_o`  out  CNT_W  high cycles within that period.
- `meas_valid`  out  1  one-cycle pulse when `period_o`/`high_o`/`in_range` update.
- `in_range`  out  1  `|period_o − EXP_PERIOD| ≤ TOL`.
- `stalled`  out  1  no rising edge for `TIMEOUT` cycles.

## Operation
- Input path:
  - `sig_in` passes through a 2-FF synchronizer, giving `sig_s`.
  - `sig_d` is `sig_s` delayed by one cycle.
  - `rise = sig_s & ~sig_d`.
- Period counter `pcnt`:
  - Loads 1 on `rise`.
  - Otherwise increments, saturating at 2^CNT_W−1.
- High counter `hcnt`:
  - Loads 1 on `rise`.
  - Otherwise increments when `sig_s` = 1.
  - Saturates like `pcnt`.
- States:
  - IDLE: from reset. On `rise`, go to ARMED. No output.
  - ARMED: on `rise`, capture `period_o ← pcnt`, `high_o ← hcnt`, `in_range ← range check(pcnt)` and pulse `meas_valid`; stay in ARMED. If `pcnt` = TIMEOUT and there is no `rise`, go to STALLED.
  - STALLED: `stalled` = 1. On `rise`, clear `stalled` and go to ARMED without a capture, because that period is partial.
- Range check:
  - Computed on CNT_W+1-bit unsigned arithmetic: `pcnt ≥ EXP_PERIOD−TOL` and `pcnt ≤ EXP_PERIOD+TOL`.
  - A lower bound below 0 clamps to 0.
- Simultaneous events: if `rise` coincides with `pcnt` = TIMEOUT in ARMED, `rise` wins. The block captures and does not stall.
- Reset value of every output is 0, and the state returns to IDLE. Reset mid-measurement discards the partial period; the first valid result comes only after two new rising edges.

## Timing
- Latency from a `sig_in` rising edge to the `rise` cycle is 2–3 `clk_in` cycles, due to synchronizer phase.
- The capture registers update and `meas_valid` pulses on the clock edge that ends the `rise` cycle, one cycle after `rise`.
- Outputs hold between pulses.
- The measured period is exact for an input synchronous to `clk_in`, and ±1 cycle jitter for a truly asynchronous input.
- `sig_in` high or low for less than 2 cycles may be missed.
- The duty cycle is not checked.
- `stalled` asserts one cycle after `pcnt` reaches TIMEOUT.

## Structure
- Shared package `clk_meter_pkg`:
  - State enum `meter_state_t` (IDLE, ARMED, STALLED).
  - Default constants `METER_CNT_W`, `METER_TIMEOUT`.
- Sub-module `sync_edge_detect` holds the 2-FF synchronizer, the delay register, and outputs `sig_s` and `rise`. It is reusable by the I2C and button inputs.
- The top level holds the counters, FSM and capture registers.

## Test plan
- Drive `sig_in` from the 256-cycle divider output, synchronous, 50% duty, with defaults. Expect:
  - No pulse at the first edge.
  - From the second edge on, a `meas_valid` pulse every 256 cycles.
  - `period_o` = 256, `high_o` = 128, `in_range` = 1.
- Drive `sig_in` with a 300-cycle period, high 150 (I2C divider rate). Expect `period_o` = 300, `high_o` = 150, `in_range` = 0.
- Tolerance boundaries: with a 258-cycle period, `in_range` = 1; with 259, `in_range` = 0; with 254, `in_range` = 1; with 253, `in_range` = 0.
- Stall: set `TIMEOUT` = 1000, run a 256-cycle wave, then hold it low. Expect:
  - `stalled` = 1 exactly 1000 cycles after the last `rise`, plus 1 cycle.
  - On restart, `stalled` clears at the first `rise` with no pulse.
  - The next pulse reports 256.
- Reset: assert `rst_n` = 0 mid-period for 3 cycles. Expect:
  - All outputs 0 immediately; the asynchronous clear does not wait for a clock edge.
  - After release, the first `meas_valid` follows the second rising edge with `period_o` = 256.
- Asynchronous input: run a 256-cycle wave from an unrelated clock at a 37-cycle phase offset. Expect every `period_o` within 255–257 and `in_range` = 1.
